// File: rtl/bcd_updown_counter_n.sv
// Multi-digit BCD up/down counter advanced by an internal clock-enable prescaler.
// Supports synchronous load with digit clamping, wrap/saturate limits and a terminal-count pulse.
module bcd_updown_counter_n #(
    parameter int DIGITS   = 4,
    parameter int DIV      = 25000000,
    parameter int DIV_W    = 25,
    parameter int SATURATE = 0
) (
    input  logic                  mclk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   cnt,
    output logic                  tick,
    output logic                  tc
);

    logic [DIV_W-1:0]    pre_q;
    logic [4*DIGITS-1:0] cnt_q;
    logic [4*DIGITS-1:0] cnt_d;
    logic                tick_q;
    logic                tc_q;
    logic                step;
    logic                limit;

    function automatic logic [4*DIGITS-1:0] clamp_bcd(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    assign step = en && (pre_q == DIV_W'(DIV - 1));

    // Ripple carry/borrow through the decades; a carry out of the top digit marks the limit.
    always_comb begin
        logic                carry;
        logic [3:0]          dig;
        logic [3:0]          nd;
        logic [4*DIGITS-1:0] stepped;
        logic [4*DIGITS-1:0] held;
        carry   = 1'b1;
        dig     = 4'd0;
        nd      = 4'd0;
        stepped = '0;
        held    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            dig = cnt_q[4*i +: 4];
            if (dig > 4'd9) dig = 4'd9;
            nd = dig;
            if (carry) begin
                if (!mode) begin
                    if (dig == 4'd9) begin
                        nd = 4'd0;
                    end else begin
                        nd    = dig + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (dig == 4'd0) begin
                        nd = 4'd9;
                    end else begin
                        nd    = dig - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            stepped[4*i +: 4] = nd;
            held[4*i +: 4]    = dig;
        end
        limit = carry;
        cnt_d = ((SATURATE != 0) && carry) ? held : stepped;
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            cnt_q  <= '0;
            pre_q  <= '0;
            tick_q <= 1'b0;
            tc_q   <= 1'b0;
        end else if (load) begin
            cnt_q  <= clamp_bcd(load_val);
            pre_q  <= '0;
            tick_q <= 1'b0;
            tc_q   <= 1'b0;
        end else if (step) begin
            cnt_q  <= cnt_d;
            pre_q  <= '0;
            tick_q <= 1'b1;
            tc_q   <= limit;
        end else begin
            tick_q <= 1'b0;
            tc_q   <= 1'b0;
            if (en) pre_q <= pre_q + DIV_W'(1);
        end
    end

    assign cnt  = cnt_q;
    assign tick = tick_q;
    assign tc   = tc_q;

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Bench for bcd_updown_counter_n: wrap and saturate instances share stimulus,
// an integer-valued model is checked every cycle, plus hand-computed checkpoints.
module tb_bcd_updown_counter_n;

    localparam int DIGITS = 2;
    localparam int DIV    = 4;
    localparam int DIV_W  = 3;
    localparam int W      = 4 * DIGITS;
    localparam int LIM    = 99;

    logic         mclk;
    logic         rst;
    logic         en;
    logic         mode;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] cnt_w,  cnt_s;
    logic         tick_w, tick_s;
    logic         tc_w,   tc_s;

    int n_vec = 0;
    int n_err = 0;

    bcd_updown_counter_n #(.DIGITS(DIGITS), .DIV(DIV), .DIV_W(DIV_W), .SATURATE(0)) dut_w (
        .mclk(mclk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
        .cnt(cnt_w), .tick(tick_w), .tc(tc_w)
    );

    bcd_updown_counter_n #(.DIGITS(DIGITS), .DIV(DIV), .DIV_W(DIV_W), .SATURATE(1)) dut_s (
        .mclk(mclk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
        .cnt(cnt_s), .tick(tick_s), .tc(tc_s)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd_clamped(input logic [W-1:0] b);
        int v;
        int d;
        v = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = int'(b[4*i +: 4]);
            if (d > 9) d = 9;
            v = v * 10 + d;
        end
        return v;
    endfunction

    // Behavioural model: counts held as plain integers 0..99.
    int m_w = 0, m_s = 0, m_pre = 0;
    bit m_tick_w = 0, m_tc_w = 0, m_tick_s = 0, m_tc_s = 0;

    always @(posedge mclk) begin
        m_tick_w = 0; m_tc_w = 0; m_tick_s = 0; m_tc_s = 0;
        if (rst) begin
            m_w = 0; m_s = 0; m_pre = 0;
        end else if (load) begin
            m_w   = from_bcd_clamped(load_val);
            m_s   = m_w;
            m_pre = 0;
        end else if (en) begin
            if (m_pre == DIV - 1) begin
                m_pre = 0;
                m_tick_w = 1; m_tick_s = 1;
                if (!mode) begin
                    m_tc_w = (m_w == LIM);
                    m_tc_s = (m_s == LIM);
                    m_w = (m_w + 1) % (LIM + 1);
                    m_s = (m_s == LIM) ? LIM : m_s + 1;
                end else begin
                    m_tc_w = (m_w == 0);
                    m_tc_s = (m_s == 0);
                    m_w = (m_w == 0) ? LIM : m_w - 1;
                    m_s = (m_s == 0) ? 0 : m_s - 1;
                end
            end else begin
                m_pre = m_pre + 1;
            end
        end
    end

    always @(posedge mclk) begin
        #1;
        n_vec++;
        if (cnt_w !== to_bcd(m_w) || tick_w !== m_tick_w || tc_w !== m_tc_w) begin
            n_err++;
            $display("FAIL model_wrap t=%0t: cnt=%h tick=%b tc=%b required cnt=%h tick=%b tc=%b",
                     $time, cnt_w, tick_w, tc_w, to_bcd(m_w), m_tick_w, m_tc_w);
        end
        n_vec++;
        if (cnt_s !== to_bcd(m_s) || tick_s !== m_tick_s || tc_s !== m_tc_s) begin
            n_err++;
            $display("FAIL model_sat t=%0t: cnt=%h tick=%b tc=%b required cnt=%h tick=%b tc=%b",
                     $time, cnt_s, tick_s, tc_s, to_bcd(m_s), m_tick_s, m_tc_s);
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act_cnt, input logic act_tick,
                       input logic act_tc, input logic [W-1:0] exp_cnt, input logic exp_tick,
                       input logic exp_tc);
        n_vec++;
        if (act_cnt !== exp_cnt || act_tick !== exp_tick || act_tc !== exp_tc) begin
            n_err++;
            $display("FAIL %s: cnt=%h tick=%b tc=%b required cnt=%h tick=%b tc=%b",
                     name, act_cnt, act_tick, act_tc, exp_cnt, exp_tick, exp_tc);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge mclk);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0; load_val = '0;
        cyc(2);
        chk("reset", cnt_w, tick_w, tc_w, 8'h00, 1'b0, 1'b0);

        // Up count with carry and wrap
        rst = 1'b0; en = 1'b1;
        cyc(3);
        chk("no_step_before_div", cnt_w, tick_w, tc_w, 8'h00, 1'b0, 1'b0);
        cyc(1);
        chk("first_up", cnt_w, tick_w, tc_w, 8'h01, 1'b1, 1'b0);
        cyc(36);
        chk("carry_10", cnt_w, tick_w, tc_w, 8'h10, 1'b1, 1'b0);
        cyc(4 * 89);
        chk("reach_99", cnt_w, tick_w, tc_w, 8'h99, 1'b1, 1'b0);
        cyc(4);
        chk("wrap_00", cnt_w, tick_w, tc_w, 8'h00, 1'b1, 1'b1);
        chk("sat_hold_99", cnt_s, tick_s, tc_s, 8'h99, 1'b1, 1'b1);
        cyc(1);
        chk("tc_one_cycle", cnt_w, tick_w, tc_w, 8'h00, 1'b0, 1'b0);

        // Down count with wrap and borrow
        mode = 1'b1;
        cyc(3);
        chk("down_wrap_99", cnt_w, tick_w, tc_w, 8'h99, 1'b1, 1'b1);
        cyc(4);
        chk("down_98", cnt_w, tick_w, tc_w, 8'h98, 1'b1, 1'b0);
        cyc(32);
        chk("down_90", cnt_w, tick_w, tc_w, 8'h90, 1'b1, 1'b0);
        cyc(4);
        chk("borrow_89", cnt_w, tick_w, tc_w, 8'h89, 1'b1, 1'b0);

        // Load coincident with a step, digit clamp
        mode = 1'b0;
        cyc(3);
        load = 1'b1; load_val = 8'h3C;
        cyc(1);
        load = 1'b0;
        chk("load_clamp_39", cnt_w, tick_w, tc_w, 8'h39, 1'b0, 1'b0);
        cyc(3);
        chk("load_no_early_tick", cnt_w, tick_w, tc_w, 8'h39, 1'b0, 1'b0);
        cyc(1);
        chk("after_load_40", cnt_w, tick_w, tc_w, 8'h40, 1'b1, 1'b0);

        // Enable drop at 45 with prescaler at 2
        cyc(20);
        chk("at_45", cnt_w, tick_w, tc_w, 8'h45, 1'b1, 1'b0);
        cyc(2);
        en = 1'b0;
        cyc(10);
        chk("en_hold_45", cnt_w, tick_w, tc_w, 8'h45, 1'b0, 1'b0);
        en = 1'b1;
        cyc(1);
        chk("resume_pre3", cnt_w, tick_w, tc_w, 8'h45, 1'b0, 1'b0);
        cyc(1);
        chk("resume_46", cnt_w, tick_w, tc_w, 8'h46, 1'b1, 1'b0);

        // Reset mid-count at 57, then mode toggles between steps
        cyc(44);
        chk("at_57", cnt_w, tick_w, tc_w, 8'h57, 1'b1, 1'b0);
        cyc(2);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("mid_reset", cnt_w, tick_w, tc_w, 8'h00, 1'b0, 1'b0);
        mode = 1'b1;
        cyc(3);
        chk("reset_full_period", cnt_w, tick_w, tc_w, 8'h00, 1'b0, 1'b0);
        cyc(1);
        chk("post_reset_down", cnt_w, tick_w, tc_w, 8'h99, 1'b1, 1'b1);
        chk("sat_down_hold_00", cnt_s, tick_s, tc_s, 8'h00, 1'b1, 1'b1);
        cyc(2);
        mode = 1'b0;
        cyc(1);
        chk("mode_toggle_no_step", cnt_w, tick_w, tc_w, 8'h99, 1'b0, 1'b0);
        cyc(1);
        chk("mode_toggle_up", cnt_w, tick_w, tc_w, 8'h00, 1'b1, 1'b1);
        chk("sat_toggle_up", cnt_s, tick_s, tc_s, 8'h01, 1'b1, 1'b0);

        // Saturate: load 98 and count up into the limit
        load = 1'b1; load_val = 8'h98;
        cyc(1);
        load = 1'b0;
        cyc(4);
        chk("sat_step1", cnt_s, tick_s, tc_s, 8'h99, 1'b1, 1'b0);
        cyc(4);
        chk("sat_step2", cnt_s, tick_s, tc_s, 8'h99, 1'b1, 1'b1);
        chk("wrap_step2", cnt_w, tick_w, tc_w, 8'h00, 1'b1, 1'b1);
        cyc(4);
        chk("sat_step3", cnt_s, tick_s, tc_s, 8'h99, 1'b1, 1'b1);
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
